// File: rtl/rbs_pipe.sv
// Pipelined N-bit ripple-borrow subtractor: diff = a - b - b_in mod 2^N, borrow-out b_out; optional ovf under RBS_OVERFLOW_EN.
// Latency S = N/K cycles from accept to out_valid, one transaction per cycle.
// Backpressure: whole pipeline advances when !out_valid | out_ready; in_ready mirrors that advance.
module rbs_pipe #(
    parameter int N = 8,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         b_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         b_out
`ifdef RBS_OVERFLOW_EN
    ,
    output logic         ovf
`endif
);

    localparam int S = N / K;

    if (K < 1 || (N % K) != 0) begin : g_bad_cfg
        $error("rbs_pipe: N must be a non-zero multiple of K");
    end

    logic advance;

    assign advance  = !out_valid | out_ready;
    assign in_ready = advance;

    for (genvar j = 0; j < S; j++) begin : g_stg
        // W: operand bits still to be consumed at this stage; D: result bits produced so far.
        localparam int W = N - j * K;
        localparam int D = (j + 1) * K;

        logic [W-1:0] src_a;
        logic [W-1:0] src_b;
        logic         src_bi;
        logic         src_v;
        logic [K:0]   sub;
        logic [D-1:0] nxt_d;

        logic         vld;
        logic         bo;
        logic [D-1:0] rd;
`ifdef RBS_OVERFLOW_EN
        logic [1:0]   src_s;
        logic [1:0]   sg;
`endif

        if (j == 0) begin : g_head
            assign src_a  = a;
            assign src_b  = b;
            assign src_bi = b_in;
            assign src_v  = in_valid & in_ready;
            assign nxt_d  = sub[K-1:0];
`ifdef RBS_OVERFLOW_EN
            assign src_s  = {a[N-1], b[N-1]};
`endif
        end else begin : g_body
            assign src_a  = g_stg[j-1].g_op.ra;
            assign src_b  = g_stg[j-1].g_op.rb;
            assign src_bi = g_stg[j-1].bo;
            assign src_v  = g_stg[j-1].vld;
            assign nxt_d  = {sub[K-1:0], g_stg[j-1].rd};
`ifdef RBS_OVERFLOW_EN
            assign src_s  = g_stg[j-1].sg;
`endif
        end

        assign sub = {1'b0, src_a[K-1:0]} - {1'b0, src_b[K-1:0]} - {{K{1'b0}}, src_bi};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld <= 1'b0;
                bo  <= 1'b0;
                rd  <= '0;
`ifdef RBS_OVERFLOW_EN
                sg  <= 2'b00;
`endif
            end else if (advance) begin
                vld <= src_v;
                bo  <= sub[K];
                rd  <= nxt_d;
`ifdef RBS_OVERFLOW_EN
                sg  <= src_s;
`endif
            end
        end

        // Higher operand chunks ride along until the stage that consumes them.
        if (j < S - 1) begin : g_op
            logic [W-K-1:0] ra;
            logic [W-K-1:0] rb;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ra <= '0;
                    rb <= '0;
                end else if (advance) begin
                    ra <= src_a[W-1:K];
                    rb <= src_b[W-1:K];
                end
            end
        end
    end

    assign out_valid = g_stg[S-1].vld;
    assign diff      = g_stg[S-1].rd;
    assign b_out     = g_stg[S-1].bo;

`ifdef RBS_OVERFLOW_EN
    // sg = {sign of a, sign of b} of the transaction currently at the output.
    assign ovf = (g_stg[S-1].sg[1] ^ g_stg[S-1].sg[0]) & (diff[N-1] ^ g_stg[S-1].sg[1]);
`endif

endmodule

// File: tb/tb_rbs_pipe.sv
// Scoreboard bench for rbs_pipe: randomized and directed operands against an arithmetic model.
module tb_rbs_pipe;
    localparam int N = 8;
    localparam int K = 4;
    localparam int S = N / K;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         b_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] diff;
    logic         b_out;
`ifdef RBS_OVERFLOW_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    rbs_pipe #(.N(N), .K(K)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .b_out     (b_out)
`ifdef RBS_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    typedef struct {
        logic [N-1:0] d;
        logic         bo;
        logic         ov;
        int           acc_cyc;
    } exp_t;

    exp_t         sbq[$];
    int           n_chk = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           last_nrdy = -1;
    logic         stall_prev = 1'b0;
    logic [N-1:0] held_d;
    logic         held_bo;
    logic         rand_done;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, req, $time);
        end
    endfunction

    // Reference: plain integer arithmetic on the whole operands.
    function automatic exp_t model(logic [N-1:0] x, logic [N-1:0] y, logic bi);
        longint xi = longint'(x);
        longint yi = longint'(y);
        longint m  = longint'(1) << N;
        longint bl = longint'(bi);
        exp_t   e;
        e.d  = N'((xi - yi - bl + m) % m);
        e.bo = (xi < yi + bl);
        e.ov = (x[N-1] != y[N-1]) && (e.d[N-1] != x[N-1]);
        e.acc_cyc = 0;
        return e;
    endfunction

    // Monitor: observes handshakes mid-cycle, before the edge that commits them.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            cyc++;
            if (stall_prev) begin
                chk("stall_hold_valid", out_valid, 1);
                chk("stall_hold_diff", diff, held_d);
                chk("stall_hold_bout", b_out, held_bo);
            end
            if (!out_ready) last_nrdy = cyc;
            if (out_ready) chk("in_ready_open", in_ready, 1);
            else if (sbq.size() == S) chk("in_ready_full", in_ready, 0);
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("spurious_output", out_valid, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("diff", diff, e.d);
                    chk("b_out", b_out, e.bo);
`ifdef RBS_OVERFLOW_EN
                    chk("ovf", ovf, e.ov);
`endif
                    if (last_nrdy < e.acc_cyc) chk("latency", cyc - e.acc_cyc, S);
                end
            end else if (out_valid && sbq.size() == 0) begin
                chk("spurious_output", out_valid, 0);
            end
            stall_prev = out_valid && !out_ready;
            held_d     = diff;
            held_bo    = b_out;
            if (in_valid && in_ready) begin
                e = model(a, b, b_in);
                e.acc_cyc = cyc;
                sbq.push_back(e);
            end
        end
    end

    task automatic send(input logic [N-1:0] x, input logic [N-1:0] y, input logic bi);
        logic hs;
        hs = 1'b0;
        a = x;
        b = y;
        b_in = bi;
        in_valid = 1'b1;
        for (int t = 0; t < 200 && !hs; t++) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("send_accepted", hs, 1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int t = 0; t < 100 && sbq.size() != 0; t++) @(posedge clk);
        #1;
        chk("drain_empty", sbq.size(), 0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_diff", diff, 0);
        chk("rst_b_out", b_out, 0);
`ifdef RBS_OVERFLOW_EN
        chk("rst_ovf", ovf, 0);
`endif
        sbq.delete();
        stall_prev = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] rnd_op();
        logic [N-1:0] v;
        v = N'($urandom);
        case ($urandom_range(0, 5))
            0: v = '0;
            1: v = '1;
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        logic [N-1:0] ones;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        ones = '1;

        // Reset state, then open the output side.
        do_reset();
        out_ready = 1'b1;
        @(negedge clk);
        chk("in_ready_after_release", in_ready, 1);
        @(posedge clk);
        #1;

        // Single ops and boundaries.
        send(N'(8'h10), N'(8'h01), 1'b0);
        drain();
        send(N'(8'h00), N'(8'h01), 1'b0);
        send(N'(8'h05), N'(8'h05), 1'b1);
        send(N'(8'h5A), N'(8'h5A), 1'b0);
        send('0, ones, 1'b1);
        send(N'(8'h80), N'(8'h01), 1'b0);
        send(N'(8'h7F), N'(8'hFF), 1'b0);
        send(N'(8'h05), N'(8'h03), 1'b0);
        drain();

        // Back-to-back, then a stall long enough to fill the pipe.
        for (int i = 0; i < 4; i++) send(N'(8'h20 + i), N'(i), 1'b0);
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(N'(8'h30 + 3 * i), N'(i), 1'(i));
            end
            begin
                repeat (S + 3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Full pipe with output and input accepted in the same cycle.
        for (int i = 0; i < 3 * S + 2; i++) send(rnd_op(), rnd_op(), 1'($urandom));
        drain();

        // Reset with transactions in flight.
        for (int i = 0; i < S + 1; i++) send(N'(8'h44 + i), N'(8'h11), 1'b0);
        do_reset();
        out_ready = 1'b1;
        repeat (S + 4) @(posedge clk);
        #1;
        chk("no_stale_after_reset", out_valid, 0);
        send(N'(8'h09), N'(8'h0A), 1'b1);
        drain();

        // Randomized traffic with random backpressure and gaps.
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    ra = rnd_op();
                    rb = ($urandom_range(0, 7) == 0) ? ra : rnd_op();
                    send(ra, rb, 1'($urandom));
                    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1, "timeout");
    end

endmodule
